// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one load/store unit between the core and the debug port.
// One access in flight at a time; every output, memory side included, comes straight from a flop.
module lsu_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [1:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rsp_valid_o,
    output logic              core_rsp_err_o,
    output logic [31:0]       core_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [1:0]        dbg_size_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rsp_valid_o,
    output logic              dbg_rsp_err_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic              mem_byte_o,
    output logic              mem_halfword_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;
    logic              owner_dbg_q, owner_dbg_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              core_gnt_q, core_gnt_d, dbg_gnt_q, dbg_gnt_d;
    logic              core_vld_q, core_vld_d, dbg_vld_q, dbg_vld_d;
    logic              core_err_q, core_err_d, dbg_err_q, dbg_err_d;
    logic [31:0]       core_rdata_q, core_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic              mem_byte_q, mem_byte_d, mem_hw_q, mem_hw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic              win_core, win_dbg, sel_we, mis, rsp_go;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // On a tie the requester that did not win last time gets the slot.
    assign win_core  = core_req_i & (~dbg_req_i | last_dbg_q);
    assign win_dbg   = dbg_req_i & ~win_core;
    assign sel_we    = win_dbg ? dbg_we_i    : core_we_i;
    assign sel_size  = win_dbg ? dbg_size_i  : core_size_i;
    assign sel_addr  = win_dbg ? dbg_addr_i  : core_addr_i;
    assign sel_wdata = win_dbg ? dbg_wdata_i : core_wdata_i;
    assign mis       = ((sel_size == 2'b01) & sel_addr[0]) | (sel_size[1] & (|sel_addr[1:0]));

    always_comb begin
        state_d      = state_q;
        last_dbg_d   = last_dbg_q;
        owner_dbg_d  = owner_dbg_q;
        we_d         = we_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        core_gnt_d   = 1'b0;
        dbg_gnt_d    = 1'b0;
        core_vld_d   = 1'b0;
        dbg_vld_d    = 1'b0;
        core_err_d   = 1'b0;
        dbg_err_d    = 1'b0;
        core_rdata_d = core_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_byte_d   = 1'b0;
        mem_hw_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        rsp_go       = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                if (win_core | win_dbg) begin
                    state_d     = ISSUE;
                    owner_dbg_d = win_dbg;
                    last_dbg_d  = win_dbg;
                    we_d        = sel_we;
                    err_d       = mis;
                    core_gnt_d  = win_core;
                    dbg_gnt_d   = win_dbg;
                    // Memory strobes are set up here so they appear registered in ISSUE.
                    if (!mis) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_byte_d  = (sel_size == 2'b00);
                        mem_hw_d    = (sel_size == 2'b01);
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (err_q || we_q) begin
                    state_d = RESP;
                    rsp_go  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    rsp_go  = 1'b1;
                    if (owner_dbg_q) dbg_rdata_d  = mem_rdata_i;
                    else             core_rdata_d = mem_rdata_i;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp_go) begin
            core_vld_d = ~owner_dbg_q;
            dbg_vld_d  = owner_dbg_q;
            core_err_d = ~owner_dbg_q & err_q;
            dbg_err_d  = owner_dbg_q & err_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_dbg_q   <= 1'b1;
            owner_dbg_q  <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            core_gnt_q   <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            core_vld_q   <= 1'b0;
            dbg_vld_q    <= 1'b0;
            core_err_q   <= 1'b0;
            dbg_err_q    <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_byte_q   <= 1'b0;
            mem_hw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dbg_q   <= last_dbg_d;
            owner_dbg_q  <= owner_dbg_d;
            we_q         <= we_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            core_gnt_q   <= core_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            core_vld_q   <= core_vld_d;
            dbg_vld_q    <= dbg_vld_d;
            core_err_q   <= core_err_d;
            dbg_err_q    <= dbg_err_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_byte_q   <= mem_byte_d;
            mem_hw_q     <= mem_hw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign core_gnt_o       = core_gnt_q;
    assign dbg_gnt_o        = dbg_gnt_q;
    assign core_rsp_valid_o = core_vld_q;
    assign dbg_rsp_valid_o  = dbg_vld_q;
    assign core_rsp_err_o   = core_err_q;
    assign dbg_rsp_err_o    = dbg_err_q;
    assign core_rdata_o     = core_rdata_q;
    assign dbg_rdata_o      = dbg_rdata_q;
    assign mem_en_o         = mem_en_q;
    assign mem_we_o         = mem_we_q;
    assign mem_byte_o       = mem_byte_q;
    assign mem_halfword_o   = mem_hw_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign busy_o           = busy_q;

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Shares the single load/store unit (data memory + memory-mapped IO, 12-bit address space) between two requesters: the core datapath and a debug/program-loader port.
- Round-robin arbitration, one outstanding access at a time, fixed read latency from the memory side.
- Registered memory-side outputs; per-requester grant pulse and response pulse.
- Sits between the core's memory-access stage / debug bridge and the LSU.

Parameters:
- ADDR_W, 12, address width of requests and mem_addr_o.
- RD_LATENCY, 1, cycles from issue cycle to mem_rdata_i valid; legal 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- core_req_i  in  1  core request; level, held until core_gnt_o
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- core_addr_i  in  ADDR_W  byte address
- core_wdata_i  in  32  store data, LSB-aligned
- core_gnt_o  out  1  one-cycle pulse in the issue cycle of the core's access
- core_rsp_valid_o  out  1  one-cycle response pulse
- core_rsp_err_o  out  1  qualifies core_rsp_valid_o; misaligned access
- core_rdata_o  out  32  load data; holds until next core load response
- dbg_req_i, dbg_we_i, dbg_size_i, dbg_addr_i, dbg_wdata_i  in  1/1/2/ADDR_W/32  debug requester, same semantics as core_*
- dbg_gnt_o, dbg_rsp_valid_o, dbg_rsp_err_o, dbg_rdata_o  out  1/1/1/32  debug responses, same semantics as core_*
- mem_en_o  out  1  access strobe to LSU
- mem_we_o  out  1  store enable, qualified by mem_en_o
- mem_byte_o  out  1  byte access
- mem_halfword_o  out  1  halfword access
- mem_addr_o  out  ADDR_W  address to LSU
- mem_wdata_o  out  32  store data to LSU
- mem_rdata_i  in  32  LSU load data, valid RD_LATENCY cycles after the issue cycle
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, any state, mid-access included):
  - State goes to IDLE.
  - All outputs 0, both rdata registers 0.
  - last_grant = DBG, so the core wins the first tie.
  - An interrupted access produces no response.
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration is evaluated in IDLE and RESP:
  - Only one requester active: it wins.
  - Both active: the one not equal to last_grant wins.
  - On a win: latch we/size/addr/wdata and the winner ID, update last_grant, go to ISSUE.
  - No request: RESP goes to IDLE; IDLE stays.
- Misalignment check on latched request:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠00 is misaligned.
- ISSUE (exactly 1 cycle):
  - Winner's gnt_o = 1. The requester may change or drop req the following cycle.
  - Aligned: mem_en_o = 1; mem_we_o = we; mem_byte_o = (size==00); mem_halfword_o = (size==01); mem_addr_o / mem_wdata_o = latched values.
  - Misaligned: mem_en_o = 0, go to RESP with err flag set.
  - Aligned store: go to RESP.
  - Aligned load: go to WAIT, counter loaded with RD_LATENCY-1.
- WAIT:
  - Counter decrements each cycle.
  - At 0, capture mem_rdata_i into the winner's rdata register and go to RESP.
  - WAIT lasts RD_LATENCY cycles.
- RESP (1 cycle):
  - Winner's rsp_valid_o = 1; rsp_err_o = err flag.
  - rdata is updated only by successful loads.
  - The other requester's outputs stay 0.
- mem_* outputs are 0 outside ISSUE (registered, no glitches).
- Latency, counting IDLE-with-request as cycle 0:
  - gnt in cycle 1.
  - Store/error response in cycle 2.
  - Load response in cycle 2+RD_LATENCY.
- Back-to-back: new ISSUE directly follows RESP, so the access period is 2 cycles (store) or 2+RD_LATENCY cycles (load).
- A requester must not assert req for a second access before its rsp_valid_o. Behaviour is unspecified if it does.

Test Plan:
- Core load, word, addr 0x010, RD_LATENCY=1, mem_rdata_i=0xDEADBEEF in cycle 2 -> core_gnt_o in cycle 1 with mem_en_o=1, mem_we_o=0; core_rsp_valid_o in cycle 3; core_rdata_o=0xDEADBEEF, held afterwards.
- Both requesters continuously storing from reset -> grants alternate CORE, DBG, CORE, DBG; one ISSUE every 2 cycles; mem_we_o=1 with the correct addr/wdata each time.
- Debug halfword store at addr 0x003 -> dbg_gnt_o pulse, mem_en_o stays 0, dbg_rsp_valid_o=1 with dbg_rsp_err_o=1 in cycle 2; dbg_rdata_o unchanged.
- RD_LATENCY=3 core byte load at 0x7FF -> mem_byte_o=1 in ISSUE, WAIT lasts 3 cycles, response in cycle 5, busy_o high in cycles 1-5.
- rst_ni asserted in WAIT of a debug load -> all outputs 0 immediately, no dbg_rsp_valid_o; after release, simultaneous requests grant CORE first.
- Core-only traffic with dbg_req_i=0 -> core granted every access with no idle cycle between RESP and the next ISSUE.
